mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arb_sel.sv | 52 +++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter (fetch vs. data).
// Optional feature macro: ARB_STARVE_GUARD_EN (starve counter in mem_arb_sel).
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } arb_owner_t;

   // Width able to hold 0..max_count inclusive.
   function automatic int unsigned cnt_width(int unsigned max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the shared memory.
// Optional feature macro: ARB_STARVE_GUARD_EN (no effect on this bundle).
interface mem_arbiter_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);
   // Handshake: a requester holds x_req_i until it sees a one-cycle x_gnt_o;
   // x_rvalid_o later pulses once with x_rdata_o (load data, or store ack).
   // The memory side sees mem_req_o held with stable fields until mem_gnt_i,
   // then returns mem_rvalid_i/mem_rdata_i in that cycle or a later one.
   logic              if_req_i;
   logic [AWIDTH-1:0] if_addr_i;
   logic              if_gnt_o;
   logic              if_rvalid_o;
   logic [DWIDTH-1:0] if_rdata_o;

   logic              d_req_i;
   logic              d_we_i;
   logic [AWIDTH-1:0] d_addr_i;
   logic [DWIDTH-1:0] d_wdata_i;
   logic              d_gnt_o;
   logic              d_rvalid_o;
   logic [DWIDTH-1:0] d_rdata_o;

   logic              mem_req_o;
   logic              mem_we_o;
   logic [AWIDTH-1:0] mem_addr_o;
   logic [DWIDTH-1:0] mem_wdata_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [DWIDTH-1:0] mem_rdata_i;

   // Arbiter view: it masters the shared memory bus.
   modport master (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
      output d_gnt_o, d_rvalid_o, d_rdata_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   // Environment view: requesters plus the memory model.
   modport slave (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output d_req_i, d_we_i, d_addr_i, d_wdata_i,
      input  d_gnt_o, d_rvalid_o, d_rdata_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

endinterface

// File: rtl/mem_arb_sel.sv
// Winner selection between fetch and data requests.
// With ARB_STARVE_GUARD_EN a counter forces a fetch win after STARVE_MAX data wins.
module mem_arb_sel
   import mem_arbiter_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
   parameter int STARVE_MAX = 4
)
`endif
(
`ifdef ARB_STARVE_GUARD_EN
   input  logic       clk,
   input  logic       reset,
   input  logic       grant,
`endif
   input  logic       if_req,
   input  logic       d_req,
   output arb_owner_t winner,
   output logic       any_req
);

   assign any_req = if_req | d_req;

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned CW = cnt_width(STARVE_MAX);

   logic [CW-1:0] starve_cnt;

   always_comb begin
      winner = d_req ? OWN_D : OWN_IF;
      if (if_req && (starve_cnt >= CW'(STARVE_MAX))) winner = OWN_IF;
   end

   // Counts data wins that left a fetch request waiting; any fetch win clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if (winner == OWN_IF) begin
            starve_cnt <= '0;
         end else if (if_req && (starve_cnt < CW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + CW'(1);
         end
      end
   end
`else
   always_comb begin
      winner = d_req ? OWN_D : OWN_IF;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port, one transaction in flight.
// Optional feature macro: ARB_STARVE_GUARD_EN (fetch anti-starvation in mem_arb_sel).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AWIDTH     = 32,
   parameter int DWIDTH     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   mem_arbiter_if.master bus,
   output arb_state_t dbg_state
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   arb_owner_t        owner_q;
   logic              we_q;
   logic [AWIDTH-1:0] addr_q;
   logic [DWIDTH-1:0] wdata_q;

   arb_owner_t        winner;
   logic              any_req;
   logic              grant;
   logic              resp_phase;
   logic              resp_valid;
   logic              in_req;

   mem_arb_sel
`ifdef ARB_STARVE_GUARD_EN
   #(.STARVE_MAX(STARVE_MAX))
`endif
   u_sel (
`ifdef ARB_STARVE_GUARD_EN
      .clk     (clk),
      .reset   (reset),
      .grant   (grant),
`endif
      .if_req  (bus.if_req_i),
      .d_req   (bus.d_req_i),
      .winner  (winner),
      .any_req (any_req)
   );

   // Grant is gated by reset so outputs go quiet while reset is held.
   always_comb begin
      state_nxt  = state;
      grant      = 1'b0;
      resp_phase = 1'b0;
      case (state)
         IDLE: begin
            if (any_req && reset) begin
               grant     = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (bus.mem_gnt_i) begin
               resp_phase = bus.mem_rvalid_i;
               state_nxt  = bus.mem_rvalid_i ? IDLE : WAIT;
            end
         end
         WAIT: begin
            resp_phase = 1'b1;
            if (bus.mem_rvalid_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         owner_q <= OWN_IF;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            owner_q <= winner;
            if (winner == OWN_D) begin
               we_q    <= bus.d_we_i;
               addr_q  <= bus.d_addr_i;
               wdata_q <= bus.d_wdata_i;
            end else begin
               we_q    <= 1'b0;
               addr_q  <= bus.if_addr_i;
               wdata_q <= '0;
            end
         end
      end
   end

   assign resp_valid = resp_phase & bus.mem_rvalid_i;
   assign in_req     = (state == REQ);

   assign bus.if_gnt_o    = grant && (winner == OWN_IF);
   assign bus.d_gnt_o     = grant && (winner == OWN_D);
   assign bus.if_rvalid_o = resp_valid && (owner_q == OWN_IF);
   assign bus.d_rvalid_o  = resp_valid && (owner_q == OWN_D);
   assign bus.if_rdata_o  = (resp_phase && (owner_q == OWN_IF)) ? bus.mem_rdata_i : '0;
   assign bus.d_rdata_o   = (resp_phase && (owner_q == OWN_D))  ? bus.mem_rdata_i : '0;

   assign bus.mem_req_o   = in_req;
   assign bus.mem_we_o    = in_req & we_q;
   assign bus.mem_addr_o  = in_req ? addr_q  : '0;
   assign bus.mem_wdata_o = in_req ? wdata_q : '0;

   assign dbg_state = state;

endmodule
